// File: rtl/ow_sensor_scheduler.sv
// ow_sensor_scheduler
//   Sequences one DS18B20 measurement cycle on top of a 1-Wire byte engine:
//   broadcast Skip ROM + Convert T, wait for the conversion, then for every
//   sensor Match ROM, Read Scratchpad and read 9 bytes. One temperature word
//   with an error flag is returned per sensor.
//
//   Build option: define CRC_CHECK_EN to include the Dallas CRC-8 check on the
//   scratchpad; without it temp_err only reflects a missing presence pulse.
//
// Ports
//   clk, rst_n        system clock, synchronous active-low reset
//   F1M               1 MHz tick enable for the conversion wait
//   start             begin a measurement cycle (ignored while busy)
//   rom_codes         64-bit ROM code per sensor, family byte in [7:0]
//   op_valid/op_code/op_byte   request to byte engine (0=RESET,1=WRITE,2=READ)
//   op_done/op_rx_byte/op_presence   completion from byte engine
//   busy, cycle_done, no_device      cycle status
//   temp_valid/temp_idx/temp_data/temp_err   per-sensor result
//
// State table
//   IDLE     | waiting for start
//   CV_RST   | bus reset before conversion
//   CV_SKIP  | write Skip ROM 0xCC
//   CV_CONV  | write Convert T 0x44
//   CV_WAIT  | count CONV_TICKS F1M ticks
//   RD_RST   | bus reset before addressing sensor idx
//   RD_MATCH | write Match ROM 0x55
//   RD_ROM   | write 8 ROM bytes of sensor idx
//   RD_CMD   | write Read Scratchpad 0xBE
//   RD_DATA  | read 9 scratchpad bytes
//   RESULT   | present result of sensor idx
//   DONE     | end of cycle pulse
module ow_sensor_scheduler #(
  parameter int N_SENSORS  = 2,
  parameter int IDX_W      = 1,
  parameter int CONV_TICKS = 750000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   F1M,
  input  logic                   start,
  input  logic [64*N_SENSORS-1:0] rom_codes,
  output logic                   op_valid,
  output logic [1:0]             op_code,
  output logic [7:0]             op_byte,
  input  logic                   op_done,
  input  logic [7:0]             op_rx_byte,
  input  logic                   op_presence,
  output logic                   busy,
  output logic                   temp_valid,
  output logic [IDX_W-1:0]       temp_idx,
  output logic [15:0]            temp_data,
  output logic                   temp_err,
  output logic                   cycle_done,
  output logic                   no_device
);

  typedef enum logic [3:0] {
    S_IDLE, S_CV_RST, S_CV_SKIP, S_CV_CONV, S_CV_WAIT, S_RD_RST,
    S_RD_MATCH, S_RD_ROM, S_RD_CMD, S_RD_DATA, S_RESULT, S_DONE
  } state_t;

  localparam logic [1:0]       OP_RESET  = 2'd0;
  localparam logic [1:0]       OP_WRITE  = 2'd1;
  localparam logic [1:0]       OP_READ   = 2'd2;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_SENSORS - 1);
  localparam logic [19:0]      CONV_LAST = 20'(CONV_TICKS - 1);

  state_t           state_q, state_d;
  logic             op_valid_q;
  logic [19:0]      wait_cnt_q;
  logic [3:0]       byte_cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       b0_q, b1_q;
  logic [IDX_W-1:0] temp_idx_q;
  logic [15:0]      temp_data_q;
  logic             temp_err_q;
  logic             no_device_q;

  logic             done_acc;
  logic             op_state;
  logic [7:0]       rom_byte;
  logic             crc_fail;

  // Completions only count while a request is outstanding.
  assign done_acc = op_valid_q & op_done;

  assign op_state = (state_q == S_CV_RST)   || (state_q == S_CV_SKIP) ||
                    (state_q == S_CV_CONV)  || (state_q == S_RD_RST)  ||
                    (state_q == S_RD_MATCH) || (state_q == S_RD_ROM)  ||
                    (state_q == S_RD_CMD)   || (state_q == S_RD_DATA);

  always_comb begin
    rom_byte = 8'hFF;
    for (int i = 0; i < N_SENSORS; i++) begin
      for (int b = 0; b < 8; b++) begin
        if (idx_q == IDX_W'(i) && byte_cnt_q == 4'(b)) begin
          rom_byte = rom_codes[64*i + 8*b +: 8];
        end
      end
    end
  end

`ifdef CRC_CHECK_EN
  logic [7:0] crc_q;
  logic [7:0] crc_next;

  // Dallas CRC-8, reflected polynomial 0x8C, data LSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in,
                                           input logic [7:0] data);
    logic [7:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 8'h8C;
      else                c = c >> 1;
    end
    return c;
  endfunction

  assign crc_next = crc8_byte(crc_q, op_rx_byte);
  assign crc_fail = (crc_next != 8'h00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_q <= 8'h00;
    end else if (state_q != S_RD_DATA) begin
      crc_q <= 8'h00;
    end else if (done_acc) begin
      crc_q <= crc_next;
    end
  end
`else
  assign crc_fail = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_CV_RST;
      S_CV_RST:   if (done_acc) state_d = op_presence ? S_CV_SKIP : S_DONE;
      S_CV_SKIP:  if (done_acc) state_d = S_CV_CONV;
      S_CV_CONV:  if (done_acc) state_d = S_CV_WAIT;
      S_CV_WAIT:  if (F1M && wait_cnt_q == CONV_LAST) state_d = S_RD_RST;
      S_RD_RST:   if (done_acc) state_d = op_presence ? S_RD_MATCH : S_RESULT;
      S_RD_MATCH: if (done_acc) state_d = S_RD_ROM;
      S_RD_ROM:   if (done_acc && byte_cnt_q == 4'd7) state_d = S_RD_CMD;
      S_RD_CMD:   if (done_acc) state_d = S_RD_DATA;
      S_RD_DATA:  if (done_acc && byte_cnt_q == 4'd8) state_d = S_RESULT;
      S_RESULT:   state_d = (idx_q == LAST_IDX) ? S_DONE : S_RD_RST;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_code    = OP_RESET;
    op_byte    = 8'hFF;
    case (state_q)
      S_CV_SKIP:  begin op_code = OP_WRITE; op_byte = 8'hCC;    end
      S_CV_CONV:  begin op_code = OP_WRITE; op_byte = 8'h44;    end
      S_RD_MATCH: begin op_code = OP_WRITE; op_byte = 8'h55;    end
      S_RD_ROM:   begin op_code = OP_WRITE; op_byte = rom_byte; end
      S_RD_CMD:   begin op_code = OP_WRITE; op_byte = 8'hBE;    end
      S_RD_DATA:  op_code = OP_READ;
      default:    ;
    endcase
    busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    temp_valid = (state_q == S_RESULT);
    cycle_done = (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_valid_q  <= 1'b0;
      wait_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      idx_q       <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      temp_idx_q  <= '0;
      temp_data_q <= '0;
      temp_err_q  <= 1'b0;
      no_device_q <= 1'b0;
    end else begin
      // Request drops the cycle after done; the next one rises a cycle later.
      if (done_acc)                     op_valid_q <= 1'b0;
      else if (!op_valid_q && op_state) op_valid_q <= 1'b1;

      if (state_q == S_IDLE && start)
        no_device_q <= 1'b0;
      else if (state_q == S_CV_RST && done_acc && !op_presence)
        no_device_q <= 1'b1;

      if (state_q != S_CV_WAIT) wait_cnt_q <= '0;
      else if (F1M)             wait_cnt_q <= wait_cnt_q + 20'd1;

      if (state_d != state_q) byte_cnt_q <= '0;
      else if (done_acc)      byte_cnt_q <= byte_cnt_q + 4'd1;

      if (state_q == S_IDLE || state_q == S_CV_WAIT)
        idx_q <= '0;
      else if (state_q == S_RESULT && idx_q != LAST_IDX)
        idx_q <= idx_q + IDX_W'(1);

      if (state_q == S_RD_DATA && done_acc) begin
        if (byte_cnt_q == 4'd0) b0_q <= op_rx_byte;
        if (byte_cnt_q == 4'd1) b1_q <= op_rx_byte;
      end

      if (state_q == S_RD_RST && done_acc && !op_presence) begin
        temp_idx_q  <= idx_q;
        temp_data_q <= 16'h0000;
        temp_err_q  <= 1'b1;
      end else if (state_q == S_RD_DATA && done_acc && byte_cnt_q == 4'd8) begin
        temp_idx_q  <= idx_q;
        temp_data_q <= {b1_q, b0_q};
        temp_err_q  <= crc_fail;
      end
    end
  end

  assign op_valid  = op_valid_q;
  assign temp_idx  = temp_idx_q;
  assign temp_data = temp_data_q;
  assign temp_err  = temp_err_q;
  assign no_device = no_device_q;

endmodule

// File: doc/ow_sensor_scheduler.md
Name: ow_sensor_scheduler

Overview:
Sequencer for the 1-Wire byte engine that drives the DS18B20 bus. Each measurement cycle runs one broadcast conversion, then for each sensor: Match ROM, Read Scratchpad, 9-byte read. Issues RESET / WRITE / READ operations to the byte engine over a request/done handshake. Returns one temperature word per sensor with an error flag.

Parameters:
N_SENSORS, 2, number of sensors on the bus (1..16)
IDX_W, 1, width of sensor index, must satisfy 2**IDX_W >= N_SENSORS
CONV_TICKS, 750000, F1M ticks to wait after Convert T (750 ms at 12-bit resolution)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
F1M  in  1  1 MHz single-cycle tick enable; used only for the conversion wait counter
start  in  1  pulse; begins a measurement cycle; ignored while busy=1
rom_codes  in  64*N_SENSORS  sensor i ROM at [64*i +: 64]; bits [7:0] are the family byte and are sent first
op_valid  out  1  operation request to the byte engine
op_code  out  2  0=RESET/presence, 1=WRITE byte, 2=READ byte
op_byte  out  8  byte to write; 0xFF for READ and RESET
op_done  in  1  one-cycle completion pulse from the byte engine
op_rx_byte  in  8  read data; valid on the op_done cycle
op_presence  in  1  presence result; valid on the op_done cycle of a RESET
busy  out  1  high from the cycle after accepted start until cycle_done
temp_valid  out  1  one-cycle pulse per sensor result
temp_idx  out  IDX_W  sensor index of the result
temp_data  out  16  {scratchpad byte1, byte0}, raw DS18B20 format
temp_err  out  1  result invalid (no presence or CRC fail)
cycle_done  out  1  one-cycle pulse at end of cycle
no_device  out  1  sticky per cycle; set if conversion RESET saw no presence; cleared on accepted start

Behaviour:
- Reset: state IDLE, all outputs 0, except op_byte=0xFF and temp_data=0x0000. The wait counter and byte counters are cleared. Reset mid-operation drops op_valid on that edge. Any later op_done is ignored.
- Handshake: op_code and op_byte stay stable while op_valid=1. op_valid falls on the cycle after op_done. The next request is raised no earlier than 1 cycle later. op_done while op_valid=0 is ignored.
- State sequence:
  - IDLE -> CV_RST on start.
  - CV_RST -> CV_SKIP if presence. If no presence: set no_device, then DONE.
  - CV_SKIP writes 0xCC -> CV_CONV.
  - CV_CONV writes 0x44 -> CV_WAIT.
  - CV_WAIT counts CONV_TICKS F1M ticks -> RD_RST with idx=0.
  - RD_RST: no presence -> RESULT with err=1, data=0x0000. Otherwise -> RD_MATCH.
  - RD_MATCH writes 0x55 -> RD_ROM.
  - RD_ROM writes ROM bytes 0..7 of sensor idx -> RD_CMD.
  - RD_CMD writes 0xBE -> RD_DATA.
  - RD_DATA reads 9 bytes. Byte0 and byte1 are captured; all 9 are fed to the CRC. -> RESULT.
  - RESULT: pulse temp_valid for one cycle. If idx==N_SENSORS-1 -> DONE, else idx+1 -> RD_RST.
  - DONE: pulse cycle_done, busy=0 -> IDLE.
- Conversion wait: the counter is 20 bits, increments only on F1M=1, and exits when count==CONV_TICKS-1 on an F1M tick. The counter is cleared on entry to CV_WAIT.
- CRC: Dallas CRC-8, polynomial x^8+x^5+x^4+1 (reflected 0x8C), init 0x00. Bytes are processed LSB first. The remainder is cleared on entry to RD_DATA. A remainder of 0x00 after 9 bytes means pass.
- temp_idx, temp_data and temp_err hold their values until the next RESULT.
- start on the same cycle as cycle_done is ignored.

Optional Feature:
CRC_CHECK_EN
- Defined: the CRC-8 datapath is instantiated. In RESULT, temp_err = no-presence OR (remainder != 0).
- Undefined: no CRC logic is present. temp_err = no-presence only. All 9 bytes are still read, so bus timing is identical.

Test Plan:
- Single cycle, N_SENSORS=2, engine model always presents, scratchpad 50 05 4B 46 7F FF 0C 10 1C for both sensors -> op bytes CC,44, then per sensor 55,ROM[0..7],BE plus 9 READs; temp_valid twice, idx 0 then 1, temp_data=0x0550, temp_err=0; one cycle_done.
- Corrupt scratchpad byte 8 to 0x1D for sensor 1 -> sensor 1 temp_err=1 with CRC_CHECK_EN defined; temp_err=0 without it.
- No presence on the conversion RESET -> no_device=1; no temp_valid; cycle_done; busy=0.
- No presence on sensor 0's RD_RST only -> idx0 result temp_err=1, data 0x0000; sensor 1 reads normally.
- CONV_TICKS=5, F1M every 4th clk -> RD_RST request appears exactly after the 5th F1M tick. Also pulse start during busy -> no effect.
- rst_n low for one cycle during RD_DATA byte 4 -> op_valid=0 on the next cycle; all outputs at reset values; a stray op_done is ignored; a new start runs a clean full cycle.
